// File: rtl/data_mem_responder.sv
// data_mem_responder: word-organised data RAM answering the core's MemRead/MemWrite requests
// Ports: clk; rst (async, active-low); MemRead/MemWrite requests; dAddress byte address;
//   dWriteData in; dReadData out (held between reads); rvalid read-complete pulse;
//   busy read in flight; fault rejected-access pulse; err sticky fault flag;
//   rd_count/wr_count saturating accepted-access counters.
// Build option: define DMEM_STATS_EN to enable rd_count/wr_count (otherwise tied to 0).
module data_mem_responder #(
    parameter logic [31:0] DATA_BASE    = 32'h10010000,
    parameter int          DEPTH_WORDS  = 1024,
    parameter int          READ_LATENCY = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        MemRead,
    input  logic        MemWrite,
    input  logic [31:0] dAddress,
    input  logic [31:0] dWriteData,
    output logic [31:0] dReadData,
    output logic        rvalid,
    output logic        busy,
    output logic        fault,
    output logic        err,
    output logic [15:0] rd_count,
    output logic [15:0] wr_count
);
    localparam int         AW       = $clog2(DEPTH_WORDS);
    localparam logic       IDLE     = 1'b0;
    localparam logic       RD_WAIT  = 1'b1;
    localparam logic [2:0] CNT_INIT = 3'(READ_LATENCY - 1);

    logic [31:0]   mem [DEPTH_WORDS];
    logic [31:0]   off;
    logic [AW-1:0] idx;
    logic          ok, idle, rd_take, rd_ok, wr_ok, reject;
    logic [31:0]   rd_word;
    logic          state_q, state_d;
    logic [2:0]    cnt_q, cnt_d;
    logic [31:0]   pend_q, pend_d, rdata_q, rdata_d;
    logic          rvalid_q, rvalid_d, fault_q, fault_d, err_q, err_d;

    // Addresses below DATA_BASE wrap to a huge offset and fail the range test.
    assign off     = dAddress - DATA_BASE;
    assign idx     = off[AW+1:2];
    assign ok      = (dAddress >= DATA_BASE) && ((off >> 2) < 32'(DEPTH_WORDS)) && (dAddress[1:0] == 2'b00);
    assign idle    = state_q == IDLE;
    assign wr_ok   = MemWrite && !MemRead && ok;
    // Any read seen in IDLE completes a handshake; only a clean one returns RAM data.
    assign rd_take = idle && MemRead;
    assign rd_ok   = rd_take && !MemWrite && ok;
    assign reject  = (MemRead || MemWrite) && (!ok || (MemRead && MemWrite) || (MemRead && !idle));
    assign rd_word = rd_ok ? mem[idx] : 32'h0;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        pend_d   = pend_q;
        rdata_d  = rdata_q;
        rvalid_d = 1'b0;
        fault_d  = reject;
        err_d    = err_q | reject;
        if (!idle) begin
            cnt_d = cnt_q - 3'd1;
            if (cnt_q == 3'd1) begin
                rdata_d  = pend_q;
                rvalid_d = 1'b1;
                state_d  = IDLE;
            end
        end else if (rd_take) begin
            if (READ_LATENCY == 1) begin
                rdata_d  = rd_word;
                rvalid_d = 1'b1;
            end else begin
                pend_d  = rd_word;
                cnt_d   = CNT_INIT;
                state_d = RD_WAIT;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            pend_q   <= '0;
            rdata_q  <= '0;
            rvalid_q <= 1'b0;
            fault_q  <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            pend_q   <= pend_d;
            rdata_q  <= rdata_d;
            rvalid_q <= rvalid_d;
            fault_q  <= fault_d;
            err_q    <= err_d;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_ok) mem[idx] <= dWriteData;
    end

    assign dReadData = rdata_q;
    assign rvalid    = rvalid_q;
    assign busy      = state_q == RD_WAIT;
    assign fault     = fault_q;
    assign err       = err_q;

`ifdef DMEM_STATS_EN
    logic [15:0] rd_cnt_q, wr_cnt_q;
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_cnt_q <= '0;
            wr_cnt_q <= '0;
        end else begin
            if (rd_ok && rd_cnt_q != 16'hFFFF) rd_cnt_q <= rd_cnt_q + 16'd1;
            if (wr_ok && wr_cnt_q != 16'hFFFF) wr_cnt_q <= wr_cnt_q + 16'd1;
        end
    end
    assign rd_count = rd_cnt_q;
    assign wr_count = wr_cnt_q;
`else
    assign rd_count = '0;
    assign wr_count = '0;
`endif
endmodule

// File: tb/tb_data_mem_responder.sv
// tb_data_mem_responder: scoreboard bench for data_mem_responder at read latency 1 and 3
module tb_data_mem_responder;
    typedef struct {logic [31:0] d; int c;} exp_t;

`ifdef DMEM_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    logic clk = 1'b0, rst = 1'b0;
    logic ra = 0, wa = 0, rb = 0, wb = 0;
    logic [31:0] aa = 0, da = 0, ab = 0, db = 0;
    logic [31:0] rda, rdb;
    logic rva, rvb, bya, byb, fa, fb, ea, eb;
    logic [15:0] rca, wca, rcb, wcb;
    int cyc = 0, pass = 0, total = 0;
    exp_t qa[$], qb[$];
    int fqa[$], fqb[$];
    exp_t xa, xb;
    int fxa, fxb;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    data_mem_responder #(.DEPTH_WORDS(1024), .READ_LATENCY(1)) u_a (
        .clk(clk), .rst(rst), .MemRead(ra), .MemWrite(wa), .dAddress(aa), .dWriteData(da),
        .dReadData(rda), .rvalid(rva), .busy(bya), .fault(fa), .err(ea), .rd_count(rca), .wr_count(wca));

    data_mem_responder #(.DEPTH_WORDS(1024), .READ_LATENCY(3)) u_b (
        .clk(clk), .rst(rst), .MemRead(rb), .MemWrite(wb), .dAddress(ab), .dWriteData(db),
        .dReadData(rdb), .rvalid(rvb), .busy(byb), .fault(fb), .err(eb), .rd_count(rcb), .wr_count(wcb));

    always @(negedge clk) begin
        if (rva) begin
            total++;
            if (qa.size() == 0) $display("FAIL rd_a unexpected rvalid data=%h cyc=%0d", rda, cyc);
            else begin
                xa = qa.pop_front();
                if (rda === xa.d && cyc == xa.c) pass++;
                else $display("FAIL rd_a got data=%h cyc=%0d expected data=%h cyc=%0d", rda, cyc, xa.d, xa.c);
            end
        end
        if (fa) begin
            total++;
            if (fqa.size() == 0) $display("FAIL fault_a unexpected pulse cyc=%0d", cyc);
            else begin
                fxa = fqa.pop_front();
                if (cyc == fxa) pass++;
                else $display("FAIL fault_a got cyc=%0d expected cyc=%0d", cyc, fxa);
            end
        end
    end

    always @(negedge clk) begin
        if (rvb) begin
            total++;
            if (qb.size() == 0) $display("FAIL rd_b unexpected rvalid data=%h cyc=%0d", rdb, cyc);
            else begin
                xb = qb.pop_front();
                if (rdb === xb.d && cyc == xb.c) pass++;
                else $display("FAIL rd_b got data=%h cyc=%0d expected data=%h cyc=%0d", rdb, cyc, xb.d, xb.c);
            end
        end
        if (fb) begin
            total++;
            if (fqb.size() == 0) $display("FAIL fault_b unexpected pulse cyc=%0d", cyc);
            else begin
                fxb = fqb.pop_front();
                if (cyc == fxb) pass++;
                else $display("FAIL fault_b got cyc=%0d expected cyc=%0d", cyc, fxb);
            end
        end
    end

    task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) pass++;
        else $display("FAIL %s got=%h expected=%h", n, act, exp);
    endtask

    // Drive one request for a cycle and record what the monitors should see.
    task automatic op(input bit sel, input logic r, input logic w, input logic [31:0] a, input logic [31:0] d,
                      input bit rv, input logic [31:0] ed, input bit flt);
        int lat = sel ? 3 : 1;
        if (sel) begin rb = r; wb = w; ab = a; db = d; end
        else begin ra = r; wa = w; aa = a; da = d; end
        if (rv && sel) qb.push_back('{ed, cyc + lat});
        if (rv && !sel) qa.push_back('{ed, cyc + lat});
        if (flt && sel) fqb.push_back(cyc + 1);
        if (flt && !sel) fqa.push_back(cyc + 1);
        @(posedge clk); #1;
        ra = 0; wa = 0; rb = 0; wb = 0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        chk("rst_rdata_a", rda, 0);
        chk("rst_rvalid_a", {31'b0, rva}, 0);
        chk("rst_fault_a", {31'b0, fa}, 0);
        chk("rst_err_a", {31'b0, ea}, 0);
        chk("rst_busy_b", {31'b0, byb}, 0);
        chk("rst_counts_a", {rca, wca}, 0);
        rst = 1'b1;
        idle(1);
        op(0, 0, 1, 32'h10010004, 32'hDEADBEEF, 0, 0, 0);
        op(0, 1, 0, 32'h10010004, 0, 1, 32'hDEADBEEF, 0);
        op(0, 1, 0, 32'h10010002, 0, 1, 32'h0, 1);
        chk("err_sticky_a", {31'b0, ea}, 1);
        op(0, 0, 1, 32'h10010006, 32'h11111111, 0, 0, 1);
        op(0, 1, 0, 32'h10010004, 0, 1, 32'hDEADBEEF, 0);
        op(0, 0, 1, 32'h10010000, 32'hAAAA0000, 0, 0, 0);
        op(0, 0, 1, 32'h10010FFC, 32'hBBBB03FF, 0, 0, 0);
        op(0, 1, 0, 32'h1000FFFC, 0, 1, 32'h0, 1);
        op(0, 1, 0, 32'h10011000, 0, 1, 32'h0, 1);
        op(0, 0, 1, 32'h1000FFFC, 32'h12345678, 0, 0, 1);
        op(0, 0, 1, 32'h10011000, 32'h87654321, 0, 0, 1);
        op(0, 1, 0, 32'h10010000, 0, 1, 32'hAAAA0000, 0);
        op(0, 1, 0, 32'h10010FFC, 0, 1, 32'hBBBB03FF, 0);
        op(0, 1, 1, 32'h10010000, 32'h00000055, 1, 32'h0, 1);
        op(0, 1, 0, 32'h10010000, 0, 1, 32'hAAAA0000, 0);
        idle(2);
        chk("err_hold_a", {31'b0, ea}, 1);
        chk("wr_count_a", {16'b0, wca}, STATS ? 3 : 0);
        chk("rd_count_a", {16'b0, rca}, STATS ? 5 : 0);
        chk("busy_a_never", {31'b0, bya}, 0);

        op(1, 0, 1, 32'h10010014, 32'h5, 0, 0, 0);
        op(1, 1, 0, 32'h10010014, 0, 1, 32'h5, 0);
        chk("busy_b_wait", {31'b0, byb}, 1);
        op(1, 0, 1, 32'h10010014, 32'hA, 0, 0, 0);
        op(1, 1, 0, 32'h10010014, 0, 0, 0, 1);
        idle(3);
        chk("busy_b_done", {31'b0, byb}, 0);
        chk("err_b", {31'b0, eb}, 1);
        op(1, 1, 0, 32'h10010014, 0, 1, 32'hA, 0);
        idle(4);
        chk("wr_count_b", {16'b0, wcb}, STATS ? 2 : 0);
        chk("rd_count_b", {16'b0, rcb}, STATS ? 2 : 0);
        op(1, 1, 0, 32'h10010014, 0, 0, 0, 0);
        chk("busy_b_pre_rst", {31'b0, byb}, 1);
        #2 rst = 1'b0;
        #1;
        chk("mid_rst_rdata_b", rdb, 0);
        chk("mid_rst_busy_b", {31'b0, byb}, 0);
        chk("mid_rst_err_b", {31'b0, eb}, 0);
        chk("mid_rst_counts_b", {rcb, wcb}, 0);
        idle(1);
        rst = 1'b1;
        idle(6);
        total += qa.size() + qb.size() + fqa.size() + fqb.size();
        if (qa.size() + qb.size() + fqa.size() + fqb.size() != 0)
            $display("FAIL missing_responses got=%0d expected=0", qa.size() + qb.size() + fqa.size() + fqb.size());
        $display("%0d/%0d checks passed", pass, total);
        $finish;
    end
endmodule
